// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
// Provides the FSM state enum, default width and counter-width helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  localparam int DIV_WIDTH_DEFAULT = 4;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration.
// Ports: r/q/b in; r_next/q_next out (r is WIDTH+1 bits).
module div_restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] bx;
  logic           ge;

  // r[WIDTH] would be the bit shifted out of t; if set, t is
  // certainly >= b. It stays 0 in practice since r < b.
  always_comb begin
    t      = {r[WIDTH-1:0], q[WIDTH-1]};
    bx     = {1'b0, b};
    ge     = r[WIDTH] | (t >= bx);
    r_next = ge ? (t - bx) : t;
    q_next = {q[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_divider_ctrl.sv
// Multi-cycle unsigned divider: valid/ready in, valid/ready out.
// Ports: Clk, Rst (async high), Start/In_Ready, A, B, Sel,
// Out_Valid/Out_Ready, Quotient, Remainder, Out, Busy.
// Macro DIV_ZERO_FLAG_EN adds Div_Zero and a 1-cycle B==0 path.
module seq_divider_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic [WIDTH-1:0] Out,
  output logic             Busy
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             Div_Zero
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_q;
  logic             sel_q;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH:0]   r_nx;

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .b      (b_q),
    .r_next (r_nx),
    .q_next (q_nx)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      b_q       <= '0;
      sel_q     <= 1'b0;
      q_reg     <= '0;
      r_reg     <= '0;
      In_Ready  <= 1'b1;
      Out_Valid <= 1'b0;
      Busy      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      Out       <= '0;
`ifdef DIV_ZERO_FLAG_EN
      Div_Zero  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            b_q      <= B;
            sel_q    <= Sel;
            q_reg    <= A;
            r_reg    <= '0;
            cnt      <= '0;
            In_Ready <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            Div_Zero <= (B == '0);
            if (B == '0) begin
              Quotient  <= '1;
              Remainder <= A;
              Out       <= Sel ? A : '1;
              Out_Valid <= 1'b1;
              state     <= DONE;
            end else begin
              Busy  <= 1'b1;
              state <= ITER;
            end
`else
            Busy  <= 1'b1;
            state <= ITER;
`endif
          end
        end
        ITER: begin
          q_reg <= q_nx;
          r_reg <= r_nx;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            Busy      <= 1'b0;
            Out_Valid <= 1'b1;
            Quotient  <= q_nx;
            Remainder <= r_nx[WIDTH-1:0];
            Out       <= sel_q ? r_nx[WIDTH-1:0] : q_nx;
            state     <= DONE;
          end
        end
        DONE: begin
          if (Out_Ready) begin
            Out_Valid <= 1'b0;
            In_Ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Scoreboard bench for seq_divider_ctrl.
// Directed plan cases plus randomized ops vs. an arithmetic model.
module tb_seq_divider_ctrl;

  localparam int W = 4;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Start;
  logic         In_Ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Sel;
  logic         Out_Valid;
  logic         Out_Ready;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic [W-1:0] Out;
  logic         Busy;
`ifdef DIV_ZERO_FLAG_EN
  logic         Div_Zero;
`endif

  seq_divider_ctrl #(
    .WIDTH (W)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .In_Ready  (In_Ready),
    .A         (A),
    .B         (B),
    .Sel       (Sel),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Out       (Out),
    .Busy      (Busy)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .Div_Zero  (Div_Zero)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [W-1:0] o;
    logic         dz;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd_ready = 1'b0;
  logic ready_d;
  logic rr = 1'b0;

  assign Out_Ready = rnd_ready ? rr : ready_d;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(posedge Clk) begin
    #1;
    rr = 1'($urandom % 2);
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, req);
    end
  endtask

  // Reference: plain integer division; x/0 gives all ones, rem A.
  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic s, input int acc);
    exp_t e;
    int   ai;
    int   bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = W'(ai / bi);
      e.r = W'(ai % bi);
    end
    e.o   = s ? e.r : e.q;
    e.dz  = (bi == 0);
    e.acc = acc;
    e.lat = W;
`ifdef DIV_ZERO_FLAG_EN
    if (bi == 0) e.lat = 0;
`endif
    return e;
  endfunction

  // Monitor: compare every presented result against the queue head.
  logic pv = 1'b0;
  always @(negedge Clk) begin : mon
    exp_t e;
    if (!Rst) begin
      if (Out_Valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got Q=%0d R=%0d expected none",
                   Quotient, Remainder);
        end else begin
          e = sb[0];
          if (!pv) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("quotient", 32'(Quotient), 32'(e.q));
          chk("remainder", 32'(Remainder), 32'(e.r));
          chk("out", 32'(Out), 32'(e.o));
`ifdef DIV_ZERO_FLAG_EN
          chk("div_zero", 32'(Div_Zero), 32'(e.dz));
`endif
          if (Out_Ready) void'(sb.pop_front());
        end
      end
      pv = Out_Valid && !Out_Ready;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, output int acc);
    A     = a;
    B     = b;
    Sel   = s;
    Start = 1'b1;
    acc   = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (In_Ready && !Rst) begin
        @(posedge Clk);
        #1;
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance expected one");
    end else begin
      sb.push_back(model(a, b, s, acc));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge Clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic idle_chk(input string n);
    chk({n, "_valid"}, 32'(Out_Valid), 32'd0);
    chk({n, "_inrdy"}, 32'(In_Ready), 32'd1);
  endtask

  int a1;
  int a2;
  int tmp;
  int k;
  logic [W-1:0] ra;
  logic [W-1:0] rb;

  initial begin
    Rst     = 1'b1;
    Start   = 1'b0;
    A       = '0;
    B       = '0;
    Sel     = 1'b0;
    ready_d = 1'b0;
    #12;
    chk("rst_inrdy", 32'(In_Ready), 32'd1);
    chk("rst_valid", 32'(Out_Valid), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_q", 32'(Quotient), 32'd0);
    chk("rst_r", 32'(Remainder), 32'd0);
    chk("rst_out", 32'(Out), 32'd0);
    Rst = 1'b0;
    @(posedge Clk);
    #1;

    // Basic cases
    ready_d = 1'b1;
    issue(4'd13, 4'd3, 1'b0, tmp);
    Start = 1'b0;
    drain();
    idle_chk("pulse");
    issue(4'd13, 4'd3, 1'b1, tmp);
    issue(4'd7, 4'd9, 1'b0, tmp);
    Start = 1'b0;
    issue(4'd15, 4'd0, 1'b0, tmp);
    Start = 1'b0;
    drain();

    // Backpressure with ignored Start pulses
    ready_d = 1'b0;
    issue(4'd9, 4'd2, 1'b0, tmp);
    Start = 1'b0;
    k = 0;
    while (!Out_Valid && k < 40) begin
      @(negedge Clk);
      k++;
    end
    chk("bp_valid_seen", 32'(Out_Valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1;
      Start = ~Start;
      A     = W'($urandom);
      B     = W'($urandom);
      @(negedge Clk);
      chk("bp_inrdy", 32'(In_Ready), 32'd0);
      chk("bp_valid", 32'(Out_Valid), 32'd1);
    end
    @(posedge Clk);
    #1;
    Start   = 1'b0;
    ready_d = 1'b1;
    drain();
    idle_chk("bp_after");

    // Reset during the second ITER cycle
    issue(4'd14, 4'd5, 1'b0, tmp);
    Start = 1'b0;
    @(posedge Clk);
    #1;
    chk("iter_busy", 32'(Busy), 32'd1);
    #2;
    sb.delete();
    Rst = 1'b1;
    #1;
    chk("arst_valid", 32'(Out_Valid), 32'd0);
    chk("arst_inrdy", 32'(In_Ready), 32'd1);
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_q", 32'(Quotient), 32'd0);
    chk("arst_r", 32'(Remainder), 32'd0);
    chk("arst_out", 32'(Out), 32'd0);
    #2;
    Rst = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
    issue(4'd14, 4'd5, 1'b0, tmp);
    Start = 1'b0;
    drain();

    // Back-to-back with Start held; mid-op input changes ignored
    issue(4'd12, 4'd4, 1'b0, a1);
    A = 4'd5;
    B = 4'd5;
    issue(4'd5, 4'd5, 1'b0, a2);
    Start = 1'b0;
    chk("b2b_spacing", 32'(a2 - a1), 32'(W + 2));
    drain();

    // Randomized ops with random consumer backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom % 4 == 0) ? '0 : W'($urandom);
      issue(ra, rb, 1'($urandom % 2), tmp);
      if ($urandom % 2 == 1) begin
        Start = 1'b0;
        @(posedge Clk);
        #1;
      end
    end
    Start     = 1'b0;
    rnd_ready = 1'b0;
    ready_d   = 1'b1;
    drain();
    repeat (10) @(posedge Clk);
    #1;
    idle_chk("final");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider_ctrl.md
Name: seq_divider_ctrl

Overview:
Multi-cycle sequencer for unsigned division. It replaces the flat combinational quotient/remainder path with a shift-subtract (restoring) engine under FSM control, using a valid/ready handshake on both sides. It returns the quotient and remainder, plus a Sel-muxed Out, so it drops into the ALSU operation slots that currently use the divider top.

Parameters:
WIDTH, 4, operand/result width in bits; also the iteration count per divide.

Ports:
Clk  input  1  system clock; all state updates on its rising edge.
Rst  input  1  asynchronous, active-high reset.
Start  input  1  request valid; the operation is accepted when Start && In_Ready.
In_Ready  output  1  controller can accept a new operation.
A  input  WIDTH  dividend; sampled on acceptance only.
B  input  WIDTH  divisor; sampled on acceptance only.
Sel  input  1  output select, sampled on acceptance: 0 = quotient, 1 = remainder.
Out_Valid  output  1  result available.
Out_Ready  input  1  consumer accepts the result when Out_Valid && Out_Ready.
Quotient  output  WIDTH  registered quotient.
Remainder  output  WIDTH  registered remainder.
Out  output  WIDTH  Sel_q ? Remainder : Quotient.
Busy  output  1  high while in the ITER state.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, In_Ready=1, Out_Valid=0, Busy=0, Quotient=0, Remainder=0, Out=0, counter=0. Any in-flight operation is discarded with no output.
- States: IDLE, ITER, DONE.
- IDLE: In_Ready=1. On Start:
  - latch B and Sel;
  - set q_reg=A, r_reg=0 (WIDTH+1 bits), cnt=0;
  - go to ITER.
  - Start without acceptance has no effect.
- ITER: In_Ready=0, Busy=1. Each cycle performs one restoring step:
  - t = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  - if t >= {1'b0, B}: r_reg = t - B and shift 1 into q_reg LSB;
  - else: r_reg = t and shift 0 into q_reg LSB;
  - cnt increments. On the step with cnt==WIDTH-1, go to DONE.
  - Start is ignored in this state.
- DONE: Out_Valid=1, Quotient=q_reg, Remainder=r_reg[WIDTH-1:0].
  - Hold all outputs stable until Out_Ready; on that handshake edge go to IDLE.
  - In_Ready=0 in DONE: no overlap between result hold and a new request.
- Latency: the acceptance edge plus WIDTH edges. Out_Valid rises exactly WIDTH cycles after the acceptance cycle (4 for the default). Throughput is one op per WIDTH+2 cycles with Out_Ready held high.
- Divide-by-zero: no special path. The algorithm naturally yields Quotient=all ones and Remainder=A, still in WIDTH cycles.
- Out_Ready while not in DONE: ignored.
- Quotient/Remainder/Out keep their last result in IDLE and ITER; they change only on entry to DONE.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- When defined:
  - adds output Div_Zero (1 bit), latched at acceptance as (B==0) and valid alongside Out_Valid;
  - a B==0 request skips ITER: it goes IDLE→DONE in one cycle with Quotient=all ones, Remainder=A, Div_Zero=1;
  - Div_Zero resets to 0.
- When undefined: no Div_Zero port, and zero divisors take the normal WIDTH-cycle path with identical results.

Decomposition:
- Shared package div_pkg holds:
  - the state enum (IDLE, ITER, DONE);
  - DIV_WIDTH_DEFAULT=4;
  - the counter width as a function of WIDTH ($clog2).
- One natural sub-module, div_restore_step: combinational single-iteration logic. It takes r_reg, q_reg and B, and produces the next r_reg and q_reg.
- FSM, counter, operand registers and the output mux stay in the top.

Test Plan:
- A=13, B=3, Sel=0, Out_Ready=1 → Out_Valid 4 cycles after acceptance; Quotient=4, Remainder=1, Out=4; one-cycle pulse, then In_Ready=1.
- A=13, B=3, Sel=1 → Out=1. A=7, B=9 → Quotient=0, Remainder=7.
- A=15, B=0 → Quotient=15, Remainder=15 after 4 cycles. With DIV_ZERO_FLAG_EN: Div_Zero=1, Out_Valid 1 cycle after acceptance.
- Backpressure: A=9, B=2 with Out_Ready=0 for 5 cycles → Out_Valid, Quotient=4 and Remainder=1 held stable, In_Ready=0, Start pulses ignored. Raising Out_Ready gives one handshake, then IDLE.
- Rst asserted mid-ITER (cycle 2 of A=14, B=5) → all outputs zero asynchronously, IDLE. Next op A=14, B=5 → Quotient=2, Remainder=4.
- Back-to-back: A=12/B=4, then A=5/B=5 with Start held high → results Q=3/R=0 then Q=1/R=0, 6 cycles apart; Start changes while Busy have no effect.
